// File: rtl/pacman_render_pkg.sv
// Shared definitions for the tile map renderer: cell codes, FSM states and
// a small index-width helper used by the interface and the top.
package pacman_render_pkg;

    localparam int CELL_EMPTY  = 0;
    localparam int CELL_WALL   = 1;
    localparam int CELL_PELLET = 2;
    localparam int CELL_POWER  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAW  = 2'd3
    } state_e;

    // Index width for a count of n items; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_map_renderer_if.sv
// Map-read and plot buses of the tile map renderer.
// The renderer is the master; the map store / vga_adapter side is the slave.
interface tile_map_renderer_if
    import pacman_render_pkg::*;
#(
    parameter int GRID_W   = 20,
    parameter int GRID_H   = 15,
    parameter int CELL_W   = 2,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) ();
    localparam int GX_W = idx_w(GRID_W);
    localparam int GY_W = idx_w(GRID_H);

    logic [GX_W-1:0]     grid_x;
    logic [GY_W-1:0]     grid_y;
    logic                grid_rd;
    logic [CELL_W-1:0]   grid_data;
    logic                grid_dirty;
    logic                dirty_clr;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic                vga_plot;

    modport master (
        output grid_x, grid_y, grid_rd, dirty_clr,
        output colour, vga_x, vga_y, vga_plot,
        input  grid_data, grid_dirty
    );

    modport slave (
        input  grid_x, grid_y, grid_rd, dirty_clr,
        input  colour, vga_x, vga_y, vga_plot,
        output grid_data, grid_dirty
    );
endinterface

// File: rtl/tile_scan_counter.sv
// Nested scan counter for the renderer: pixel (px fastest, then py) inside a
// tile, and cell (gx fastest, then gy) across the map.
module tile_scan_counter #(
    parameter int GRID_W = 20,
    parameter int GRID_H = 15,
    parameter int TILE   = 8,
    parameter int GX_W   = 5,
    parameter int GY_W   = 4,
    parameter int PX_W   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            pix_step_i,
    input  logic            cell_step_i,
    output logic [PX_W-1:0] px_o,
    output logic [PX_W-1:0] py_o,
    output logic [GX_W-1:0] gx_o,
    output logic [GY_W-1:0] gy_o,
    output logic            last_pixel_o,
    output logic            last_cell_o
);
    logic [PX_W-1:0] px_q, py_q;
    logic [GX_W-1:0] gx_q;
    logic [GY_W-1:0] gy_q;
    logic            px_last_s, py_last_s, gx_last_s, gy_last_s;

    assign px_last_s = (px_q == PX_W'(TILE - 1));
    assign py_last_s = (py_q == PX_W'(TILE - 1));
    assign gx_last_s = (gx_q == GX_W'(GRID_W - 1));
    assign gy_last_s = (gy_q == GY_W'(GRID_H - 1));

    // Position counters; a cell step also rewinds the pixel position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
            py_q <= '0;
            gx_q <= '0;
            gy_q <= '0;
        end else if (clr_i) begin
            px_q <= '0;
            py_q <= '0;
            gx_q <= '0;
            gy_q <= '0;
        end else if (cell_step_i) begin
            px_q <= '0;
            py_q <= '0;
            if (gx_last_s) begin
                gx_q <= '0;
                gy_q <= gy_last_s ? '0 : gy_q + GY_W'(1);
            end else begin
                gx_q <= gx_q + GX_W'(1);
            end
        end else if (pix_step_i) begin
            if (px_last_s) begin
                px_q <= '0;
                py_q <= py_last_s ? '0 : py_q + PX_W'(1);
            end else begin
                px_q <= px_q + PX_W'(1);
            end
        end
    end

    assign px_o         = px_q;
    assign py_o         = py_q;
    assign gx_o         = gx_q;
    assign gy_o         = gy_q;
    assign last_pixel_o = px_last_s & py_last_s;
    assign last_cell_o  = gx_last_s & gy_last_s;
endmodule

// File: rtl/tile_map_renderer.sv
// Tile map renderer: walks the map grid, fetches each cell code and expands
// it into a TILE x TILE block of plots through a 4-entry palette. Optional
// dirty-only mode skips unchanged cells.
module tile_map_renderer
    import pacman_render_pkg::*;
#(
    parameter int GRID_W   = 20,
    parameter int GRID_H   = 15,
    parameter int TILE     = 8,
    parameter int CELL_W   = 2,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0,
    parameter logic [COLOUR_W-1:0] PAL0 = 3'b000,
    parameter logic [COLOUR_W-1:0] PAL1 = 3'b001,
    parameter logic [COLOUR_W-1:0] PAL2 = 3'b111,
    parameter logic [COLOUR_W-1:0] PAL3 = 3'b110
) (
    input  logic                clock_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                dirty_only,
    output logic                busy,
    output logic                done,
    tile_map_renderer_if.master bus
);
    localparam int GX_W = idx_w(GRID_W);
    localparam int GY_W = idx_w(GRID_H);
    localparam int PX_W = $clog2(TILE);

    if (TILE < 2) begin : g_bad_tile
        $error("tile_map_renderer: TILE must be at least 2");
    end
    if ((X_OFFSET + GRID_W * TILE) > (1 << X_W)) begin : g_bad_x
        $error("tile_map_renderer: map does not fit in vga_x range");
    end
    if ((Y_OFFSET + GRID_H * TILE) > (1 << Y_W)) begin : g_bad_y
        $error("tile_map_renderer: map does not fit in vga_y range");
    end

    state_e              state_q, state_d;
    logic                mode_q;
    logic [CELL_W-1:0]   cell_q;
    logic                grid_rd_q, dirty_clr_q, vga_plot_q, busy_q, done_q;
    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [COLOUR_W-1:0] colour_q;

    logic                accept_s, pix_step_s, cell_step_s, end_pass_s, draw_start_s;
    logic [PX_W-1:0]     px_s, py_s;
    logic [GX_W-1:0]     gx_s;
    logic [GY_W-1:0]     gy_s;
    logic                last_pixel_s, last_cell_s;
    logic [COLOUR_W-1:0] colour_s;
    logic [X_W-1:0]      x_s;
    logic [Y_W-1:0]      y_s;

    tile_scan_counter #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .TILE(TILE),
        .GX_W(GX_W), .GY_W(GY_W), .PX_W(PX_W)
    ) u_scan (
        .clk         (clock_50),
        .rst_n       (resetn),
        .clr_i       (accept_s),
        .pix_step_i  (pix_step_s),
        .cell_step_i (cell_step_s),
        .px_o        (px_s),
        .py_o        (py_s),
        .gx_o        (gx_s),
        .gy_o        (gy_s),
        .last_pixel_o(last_pixel_s),
        .last_cell_o (last_cell_s)
    );

    // Sequencing: fetch, wait for cell data, then draw or skip the cell.
    always_comb begin
        state_d      = state_q;
        accept_s     = 1'b0;
        pix_step_s   = 1'b0;
        cell_step_s  = 1'b0;
        end_pass_s   = 1'b0;
        draw_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with done is dropped on purpose.
                if (start && !done_q) begin
                    accept_s = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mode_q && !bus.grid_dirty) begin
                    if (last_cell_s) begin
                        end_pass_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cell_step_s = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end else begin
                    draw_start_s = 1'b1;
                    state_d      = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (last_pixel_s) begin
                    if (last_cell_s) begin
                        end_pass_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cell_step_s = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end else begin
                    pix_step_s = 1'b1;
                    state_d    = ST_DRAW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Palette lookup for the pixel currently being drawn.
    always_comb begin
        colour_s = PAL0;
        case (cell_q)
            CELL_W'(CELL_EMPTY): colour_s = PAL0;
            CELL_W'(CELL_WALL):  colour_s = PAL1;
            CELL_W'(CELL_PELLET): begin
                if ((px_s == PX_W'(TILE / 2)) && (py_s == PX_W'(TILE / 2))) begin
                    colour_s = PAL2;
                end else begin
                    colour_s = PAL0;
                end
            end
            CELL_W'(CELL_POWER): colour_s = PAL3;
            default:             colour_s = PAL0;
        endcase
    end

    assign x_s = X_W'(X_OFFSET) + X_W'(gx_s) * X_W'(TILE) + X_W'(px_s);
    assign y_s = Y_W'(Y_OFFSET) + Y_W'(gy_s) * Y_W'(TILE) + Y_W'(py_s);

    // FSM state register.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pass mode latched at start, cell code captured from the map read.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            mode_q <= 1'b0;
            cell_q <= '0;
        end else begin
            if (accept_s) begin
                mode_q <= dirty_only;
            end
            if (state_q == ST_WAIT) begin
                cell_q <= bus.grid_data;
            end
        end
    end

    // Registered outputs; plots trail the DRAW state by one cycle.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            grid_rd_q   <= 1'b0;
            dirty_clr_q <= 1'b0;
            vga_plot_q  <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            colour_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            grid_rd_q   <= (state_d == ST_FETCH);
            dirty_clr_q <= draw_start_s;
            vga_plot_q  <= (state_q == ST_DRAW);
            if (state_q == ST_DRAW) begin
                vga_x_q  <= x_s;
                vga_y_q  <= y_s;
                colour_q <= colour_s;
            end
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= end_pass_s;
        end
    end

    assign bus.grid_x    = gx_s;
    assign bus.grid_y    = gy_s;
    assign bus.grid_rd   = grid_rd_q;
    assign bus.dirty_clr = dirty_clr_q;
    assign bus.vga_plot  = vga_plot_q;
    assign bus.vga_x     = vga_x_q;
    assign bus.vga_y     = vga_y_q;
    assign bus.colour    = colour_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_tile_map_renderer.sv
// Bench for tile_map_renderer on a 2x2 map of 4x4 tiles. Expected plots are
// queued from a map model before each pass and matched against the plots
// collected from the DUT.
module tb_tile_map_renderer;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;

    logic clk = 1'b0;
    logic resetn, start, start2, dirty_only;
    logic busy1, done1, busy2, done2;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [1:0] map_code  [0:1][0:1];
    logic       map_dirty [0:1][0:1];

    plot_t exp_q[$];
    plot_t obs_q[$];
    int    done_lat, first_lat, clr_cnt;
    int    clr_x, clr_y;

    tile_map_renderer_if #(.GRID_W(2), .GRID_H(2), .CELL_W(2), .X_W(8), .Y_W(7), .COLOUR_W(3)) bus1 ();
    tile_map_renderer_if #(.GRID_W(2), .GRID_H(2), .CELL_W(2), .X_W(8), .Y_W(7), .COLOUR_W(3)) bus2 ();

    tile_map_renderer #(
        .GRID_W(2), .GRID_H(2), .TILE(4), .CELL_W(2), .X_W(8), .Y_W(7), .COLOUR_W(3),
        .X_OFFSET(0), .Y_OFFSET(0),
        .PAL0(3'b000), .PAL1(3'b001), .PAL2(3'b111), .PAL3(3'b110)
    ) dut1 (
        .clock_50(clk), .resetn(resetn), .start(start), .dirty_only(dirty_only),
        .busy(busy1), .done(done1), .bus(bus1)
    );

    tile_map_renderer #(
        .GRID_W(2), .GRID_H(2), .TILE(4), .CELL_W(2), .X_W(8), .Y_W(7), .COLOUR_W(3),
        .X_OFFSET(10), .Y_OFFSET(5),
        .PAL0(3'b000), .PAL1(3'b001), .PAL2(3'b111), .PAL3(3'b110)
    ) dut2 (
        .clock_50(clk), .resetn(resetn), .start(start2), .dirty_only(dirty_only),
        .busy(busy2), .done(done2), .bus(bus2)
    );

    logic [24:0] outs1_s, outs2_s;
    assign outs1_s = {bus1.grid_x, bus1.grid_y, bus1.grid_rd, bus1.dirty_clr, bus1.colour,
                      bus1.vga_x, bus1.vga_y, bus1.vga_plot, busy1, done1};
    assign outs2_s = {bus2.grid_x, bus2.grid_y, bus2.grid_rd, bus2.dirty_clr, bus2.colour,
                      bus2.vga_x, bus2.vga_y, bus2.vga_plot, busy2, done2};

    always #5 clk = ~clk;

    // Map store: data and dirty flag valid the cycle after a read strobe.
    always @(posedge clk) begin
        if (bus1.grid_rd) begin
            bus1.grid_data  <= map_code[bus1.grid_y][bus1.grid_x];
            bus1.grid_dirty <= map_dirty[bus1.grid_y][bus1.grid_x];
        end
        if (bus2.grid_rd) begin
            bus2.grid_data  <= map_code[bus2.grid_y][bus2.grid_x];
            bus2.grid_dirty <= map_dirty[bus2.grid_y][bus2.grid_x];
        end
    end

    function automatic logic [2:0] exp_colour(input logic [1:0] code, input int px, input int py);
        case (code)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return (px == 2 && py == 2) ? 3'b111 : 3'b000;
            default: return 3'b110;
        endcase
    endfunction

    task automatic set_map(input logic [1:0] code, input logic dirty);
        for (int gy = 0; gy < 2; gy++)
            for (int gx = 0; gx < 2; gx++) begin
                map_code[gy][gx]  = code;
                map_dirty[gy][gx] = dirty;
            end
    endtask

    task automatic build_expected(input bit dmode, input int xo, input int yo);
        plot_t p;
        exp_q.delete();
        for (int gy = 0; gy < 2; gy++)
            for (int gx = 0; gx < 2; gx++) begin
                if (dmode && !map_dirty[gy][gx]) continue;
                for (int py = 0; py < 4; py++)
                    for (int px = 0; px < 4; px++) begin
                        p.x = 8'(xo + gx * 4 + px);
                        p.y = 7'(yo + gy * 4 + py);
                        p.c = exp_colour(map_code[gy][gx], px, py);
                        exp_q.push_back(p);
                    end
            end
    endtask

    // Starts one pass and collects plots, dirty_clr pulses and done latency
    // (in clock edges after the edge that accepted start).
    task automatic run_pass(input bit which, input int restart_at, input int flip_at);
        obs_q.delete();
        done_lat = -1; first_lat = -1; clr_cnt = 0; clr_x = -1; clr_y = -1;
        @(negedge clk);
        if (which) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (which ? bus2.vga_plot : bus1.vga_plot) begin
                obs_q.push_back(which ? {bus2.vga_x, bus2.vga_y, bus2.colour}
                                      : {bus1.vga_x, bus1.vga_y, bus1.colour});
                if (first_lat < 0) first_lat = n;
            end
            if (which ? bus2.dirty_clr : bus1.dirty_clr) begin
                clr_cnt++;
                clr_x = which ? int'(bus2.grid_x) : int'(bus1.grid_x);
                clr_y = which ? int'(bus2.grid_y) : int'(bus1.grid_y);
            end
            if (which ? done2 : done1) begin
                done_lat = n;
                break;
            end
            if (n == restart_at) begin
                if (which) start2 = 1'b1; else start = 1'b1;
            end else begin
                start = 1'b0; start2 = 1'b0;
            end
            if (n == flip_at) dirty_only = ~dirty_only;
            @(negedge clk);
        end
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (outs1_s !== 25'd0) begin tests_failed++; $display("FAIL reset_in_dut1: got %h expected 0", outs1_s); end
        tests_run++;
        if (outs2_s !== 25'd0) begin tests_failed++; $display("FAIL reset_in_dut2: got %h expected 0", outs2_s); end
        @(negedge clk); resetn = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (outs1_s !== 25'd0) begin tests_failed++; $display("FAIL idle_dut1: got %h expected 0", outs1_s); end
        tests_run++;
        if (outs2_s !== 25'd0) begin tests_failed++; $display("FAIL idle_dut2: got %h expected 0", outs2_s); end
    endtask

    task automatic test_full_wall();
        plot_t e, o;
        bit    seen [0:7][0:7];
        int    dups = 0, outside = 0;
        set_map(2'd1, 1'b0); dirty_only = 1'b0;
        build_expected(1'b0, 0, 0);
        run_pass(1'b0, -1, -1);
        foreach (seen[i, j]) seen[i][j] = 1'b0;
        foreach (obs_q[i]) begin
            if (obs_q[i].x < 8 && obs_q[i].y < 8) begin
                if (seen[obs_q[i].x][obs_q[i].y]) dups++;
                seen[obs_q[i].x][obs_q[i].y] = 1'b1;
            end else outside++;
        end
        tests_run++;
        if (obs_q.size() != 64) begin tests_failed++; $display("FAIL full_count: got %0d expected 64", obs_q.size()); end
        tests_run++;
        if (dups != 0 || outside != 0) begin tests_failed++; $display("FAIL full_unique: got dups=%0d outside=%0d expected 0/0", dups, outside); end
        tests_run++;
        if (done_lat != 72) begin tests_failed++; $display("FAIL full_done_latency: got %0d expected 72", done_lat); end
        tests_run++;
        if (first_lat != 3) begin tests_failed++; $display("FAIL full_first_plot: got %0d expected 3", first_lat); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL full_plot: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b", o.x, o.y, o.c, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_pellet();
        plot_t e, o;
        int    bright = 0;
        set_map(2'd0, 1'b0); map_code[0][1] = 2'd2; dirty_only = 1'b0;
        build_expected(1'b0, 0, 0);
        run_pass(1'b0, -1, -1);
        foreach (obs_q[i]) if (obs_q[i].c == 3'b111) bright++;
        tests_run++;
        if (bright != 1) begin tests_failed++; $display("FAIL pellet_count: got %0d expected 1", bright); end
        tests_run++;
        if (obs_q.size() != 64) begin tests_failed++; $display("FAIL pellet_plots: got %0d expected 64", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL pellet_plot: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b", o.x, o.y, o.c, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_dirty_one();
        plot_t e, o;
        set_map(2'd3, 1'b0); map_dirty[1][0] = 1'b1; dirty_only = 1'b1;
        build_expected(1'b1, 0, 0);
        run_pass(1'b0, -1, 2);   // dirty_only flipped mid-pass must not matter
        dirty_only = 1'b0;
        tests_run++;
        if (obs_q.size() != 16) begin tests_failed++; $display("FAIL dirty_one_count: got %0d expected 16", obs_q.size()); end
        tests_run++;
        if (done_lat != 24) begin tests_failed++; $display("FAIL dirty_one_done: got %0d expected 24", done_lat); end
        tests_run++;
        if (clr_cnt != 1 || clr_x != 0 || clr_y != 1) begin
            tests_failed++;
            $display("FAIL dirty_clr: got n=%0d at (%0d,%0d) expected n=1 at (0,1)", clr_cnt, clr_x, clr_y);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL dirty_one_plot: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b", o.x, o.y, o.c, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen_done = 1'b0;
        set_map(2'd1, 1'b0); dirty_only = 1'b1;
        run_pass(1'b0, 3, -1);   // second start at cycle 3 lands while busy
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL clean_plots: got %0d expected 0", obs_q.size()); end
        tests_run++;
        if (done_lat != 8) begin tests_failed++; $display("FAIL clean_done: got %0d expected 8", done_lat); end
        start = 1'b1;            // coincides with done: must be ignored
        @(negedge clk);
        tests_run++;
        if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL start_on_done: got busy=%b expected 0", busy1); end
        @(negedge clk);          // start held one more cycle: accepted now
        start = 1'b0;
        tests_run++;
        if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL start_after_done: got busy=%b expected 1", busy1); end
        for (int n = 0; n < 40 && !seen_done; n++) begin
            @(negedge clk);
            if (done1) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done !== 1'b1) begin tests_failed++; $display("FAIL back_to_back_done: got %b expected 1", seen_done); end
        dirty_only = 1'b0;
    endtask

    task automatic test_reset_mid();
        int plots = 0;
        bit hit = 1'b0, saw_done = 1'b0;
        set_map(2'd1, 1'b0); dirty_only = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus1.vga_plot) plots++;
            if (plots == 10) begin
                resetn = 1'b0;
                #1;
                hit = 1'b1;
                tests_run++;
                if (outs1_s !== 25'd0) begin tests_failed++; $display("FAIL reset_mid_outputs: got %h expected 0", outs1_s); end
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_reach: got %b expected 1", hit); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done1 || busy1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_no_done: got %b expected 0", saw_done); end
        run_pass(1'b0, -1, -1);
        tests_run++;
        if (done_lat != 72 || obs_q.size() != 64) begin
            tests_failed++;
            $display("FAIL reset_mid_repass: got lat=%0d plots=%0d expected 72/64", done_lat, obs_q.size());
        end
    endtask

    task automatic test_offset();
        plot_t e, o;
        set_map(2'd1, 1'b0); dirty_only = 1'b0;
        build_expected(1'b0, 10, 5);
        run_pass(1'b1, -1, -1);
        tests_run++;
        if (obs_q.size() != 64) begin tests_failed++; $display("FAIL offset_count: got %0d expected 64", obs_q.size()); end
        if (obs_q.size() > 0) begin
            tests_run++;
            if (obs_q[0].x != 8'd10 || obs_q[0].y != 7'd5) begin
                tests_failed++;
                $display("FAIL offset_first: got (%0d,%0d) expected (10,5)", obs_q[0].x, obs_q[0].y);
            end
            tests_run++;
            if (obs_q[$].x != 8'd17 || obs_q[$].y != 7'd12) begin
                tests_failed++;
                $display("FAIL offset_last: got (%0d,%0d) expected (17,12)", obs_q[$].x, obs_q[$].y);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL offset_plot: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b", o.x, o.y, o.c, e.x, e.y, e.c);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; start2 = 1'b0; dirty_only = 1'b0;
        set_map(2'd0, 1'b0);
        repeat (3) @(negedge clk);
        test_reset();
        test_full_wall();
        test_pellet();
        test_dirty_one();
        test_back_to_back();
        test_reset_mid();
        test_offset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
